// File: rtl/bool_fn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bool_fn_pkg : shared types, limits and helpers for bool_fn_checker   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package bool_fn_pkg;

    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Counts must hold 2^n, hence one bit wider than the index.
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bool_fn_checker_minterm_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minterm_eval : combinational care/diff/ones flags for one minterm    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module minterm_eval
    import bool_fn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2**N-1:0] a,
    input  logic [2**N-1:0] b,
    input  logic [2**N-1:0] mask,
    input  logic [N-1:0]    idx,
    output logic            care,
    output logic            diff,
    output logic            a_bit,
    output logic            b_bit
);

    // a_bit/b_bit are already qualified by care so they feed the counters directly.
    assign care  = ~mask[idx];
    assign a_bit = care & a[idx];
    assign b_bit = care & b[idx];
    assign diff  = care & (a[idx] ^ b[idx]);

endmodule
`default_nettype wire

// File: rtl/bool_fn_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bool_fn_checker : sweeps all 2^N minterms comparing two truth tables |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module bool_fn_checker
    import bool_fn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2**N-1:0]     tt_a,
    input  logic [2**N-1:0]     tt_b,
    input  logic [2**N-1:0]     dc_mask,
    output logic                busy,
    output logic                done,
    output logic                equal,
    output logic [cnt_w(N)-1:0] mismatch_cnt,
    output logic                first_valid,
    output logic [N-1:0]        first_idx,
    output logic [cnt_w(N)-1:0] ones_a,
    output logic [cnt_w(N)-1:0] ones_b
);

    localparam int           W        = cnt_w(N);
    localparam int           SIZE     = 2**N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    generate
        if (N < 1 || N > MAX_N) begin : g_bad_n
            $error("bool_fn_checker: N=%0d outside 1..%0d", N, MAX_N);
        end
    endgenerate

    fsm_e            state;
    fsm_e            state_nxt;
    logic [SIZE-1:0] lat_a;
    logic [SIZE-1:0] lat_b;
    logic [SIZE-1:0] lat_m;
    logic [N-1:0]    idx;
    logic [W-1:0]    acc_mis;
    logic [W-1:0]    acc_oa;
    logic [W-1:0]    acc_ob;
    logic            acc_fv;
    logic [N-1:0]    acc_fi;

    logic            care;
    logic            diff;
    logic            a_bit;
    logic            b_bit;
    logic            start_ok;
    logic            last;

    minterm_eval #(.N(N)) u_eval (
        .a     (lat_a),
        .b     (lat_b),
        .mask  (lat_m),
        .idx   (idx),
        .care  (care),
        .diff  (diff),
        .a_bit (a_bit),
        .b_bit (b_bit)
    );

    assign start_ok = start && (state != RUN);
    assign last     = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: latch on accepted start, then one minterm per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a   <= '0;
            lat_b   <= '0;
            lat_m   <= '0;
            idx     <= '0;
            acc_mis <= '0;
            acc_oa  <= '0;
            acc_ob  <= '0;
            acc_fv  <= 1'b0;
            acc_fi  <= '0;
        end else if (start_ok) begin
            lat_a   <= tt_a;
            lat_b   <= tt_b;
            lat_m   <= dc_mask;
            idx     <= '0;
            acc_mis <= '0;
            acc_oa  <= '0;
            acc_ob  <= '0;
            acc_fv  <= 1'b0;
            acc_fi  <= '0;
        end else if (state == RUN) begin
            acc_mis <= acc_mis + {{(W-1){1'b0}}, diff};
            acc_oa  <= acc_oa  + {{(W-1){1'b0}}, a_bit};
            acc_ob  <= acc_ob  + {{(W-1){1'b0}}, b_bit};
            if (diff && !acc_fv) begin
                acc_fv <= 1'b1;
                acc_fi <= idx;
            end
            if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Output stage trails the internal view by one cycle, so the done pulse
    // still shows final results even when a back-to-back start clears the
    // accumulators on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_valid  <= 1'b0;
            first_idx    <= '0;
            ones_a       <= '0;
            ones_b       <= '0;
        end else begin
            busy         <= (state == RUN);
            done         <= (state == DONE);
            mismatch_cnt <= acc_mis;
            first_valid  <= acc_fv;
            first_idx    <= acc_fi;
            ones_a       <= acc_oa;
            ones_b       <= acc_ob;
            if (state == DONE) begin
                equal <= (acc_mis == '0);
            end else if (state == RUN) begin
                equal <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
